// File: rtl/mul_trunc_pkg.sv
// Shared limits, counter widths and Baugh-Wooley helpers for the
// truncated signed multiplier pipeline.
package mul_trunc_pkg;

  localparam int WIDTH_MIN  = 4;
  localparam int WIDTH_MAX  = 16;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;
  localparam int CNT_W      = 32;
  localparam int SUM_W      = 32;

  function automatic bit cfg_ok(int w, int d, int s);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX) &&
           (d >= 0) && (d <= w - 2) &&
           (s >= STAGES_MIN) && (s <= STAGES_MAX);
  endfunction

  // Folds the negative weights of the inverted sign row/column
  // into one constant: 2^w + 2^(2w-1), modulo 2^(2w).
  function automatic logic [31:0] bw_corr(int w);
    logic [31:0] c;
    c = '0;
    c[w] = 1'b1;
    c[2*w-1] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/mul_trunc_if.sv
// Operand/result handshake bundle for mul_trunc_pipe.
// master drives operands and out_ready; slave is the multiplier.
interface mul_trunc_if #(
  parameter int WIDTH = 8
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic signed [WIDTH-1:0]   A;
  logic signed [WIDTH-1:0]   B;
  logic                      exact;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [2*WIDTH-1:0] O;

  modport master (
    output in_valid,
    output A,
    output B,
    output exact,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  O
  );

  modport slave (
    input  in_valid,
    input  A,
    input  B,
    input  exact,
    input  out_ready,
    output in_ready,
    output out_valid,
    output O
  );

endinterface

// File: rtl/mul_trunc_array.sv
// Combinational Baugh-Wooley array; approximate mode clears the
// DROP low operand bits before partial products are formed.
module mul_trunc_array
  import mul_trunc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DROP  = 2
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               exact_i,
  output logic [2*WIDTH-1:0] p_o
);

  localparam int P = 2 * WIDTH;
  localparam logic [31:0] CORR32 = bw_corr(WIDTH);
  localparam logic [P-1:0] CORR = CORR32[P-1:0];
  localparam logic [WIDTH-1:0] KEEP = {WIDTH{1'b1}} << DROP;

  logic [WIDTH-1:0] am;
  logic [WIDTH-1:0] bm;
  logic [P-1:0]     row [WIDTH];

  always_comb begin
    am = exact_i ? a_i : (a_i & KEEP);
    bm = exact_i ? b_i : (b_i & KEEP);
  end

  // Terms mixing one sign bit with one magnitude bit are inverted.
  always_comb begin : pp_gen
    for (int r = 0; r < WIDTH; r++) begin
      row[r] = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if ((i == WIDTH - 1) != (r == WIDTH - 1))
          row[r][i+r] = ~(am[i] & bm[r]);
        else
          row[r][i+r] = am[i] & bm[r];
      end
    end
  end

  always_comb begin : reduce
    logic [P-1:0] acc;
    logic         c;
    logic         t;
    logic         s;
    acc = CORR;
    c   = 1'b0;
    t   = 1'b0;
    s   = 1'b0;
    for (int r = 0; r < WIDTH; r++) begin
      c = 1'b0;
      for (int k = 0; k < P; k++) begin
        t      = acc[k] ^ row[r][k];
        s      = t ^ c;
        c      = (acc[k] & row[r][k]) | (c & t);
        acc[k] = s;
      end
    end
    p_o = acc;
  end

endmodule

// File: rtl/mul_trunc_pipe.sv
// Pipelined exact/truncated signed multiplier with global stall.
// Define MUL_TRUNC_ERR_STATS_EN to add approximation error counters.
module mul_trunc_pipe
  import mul_trunc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DROP   = 2,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  mul_trunc_if.slave         bus
`ifdef MUL_TRUNC_ERR_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [SUM_W-1:0]   err_sum,
  output logic [2*WIDTH-1:0] err_max
`endif
);

  localparam int P = 2 * WIDTH;

  logic              en;
  logic [P-1:0]      prod_c;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [P-1:0]      prod_q [STAGES];
  logic [P-1:0]      prod_d [STAGES];

  mul_trunc_array #(
    .WIDTH (WIDTH),
    .DROP  (DROP)
  ) u_array (
    .a_i     (bus.A),
    .b_i     (bus.B),
    .exact_i (bus.exact),
    .p_o     (prod_c)
  );

  assign en           = bus.out_ready || !vld_q[STAGES-1];
  assign bus.in_ready = en;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.O        = prod_q[STAGES-1];

  always_comb begin
    vld_d  = vld_q;
    prod_d = prod_q;
    if (en) begin
      vld_d[0]  = bus.in_valid;
      prod_d[0] = prod_c;
      for (int s = 1; s < STAGES; s++) begin
        vld_d[s]  = vld_q[s-1];
        prod_d[s] = prod_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++)
        prod_q[s] <= '0;
    end else begin
      vld_q  <= vld_d;
      prod_q <= prod_d;
    end
  end

`ifdef MUL_TRUNC_ERR_STATS_EN
  logic [STAGES-1:0] ex_q;
  logic [STAGES-1:0] ex_d;
  logic [P-1:0]      err_q [STAGES];
  logic [P-1:0]      err_d [STAGES];
  logic signed [P:0] full_c;
  logic signed [P:0] diff_c;
  logic [P-1:0]      err_c;
  logic [P-1:0]      err_out;
  logic              fire;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [SUM_W-1:0]  sum_q;
  logic [SUM_W-1:0]  sum_d;
  logic [SUM_W:0]    sum_x;
  logic [P-1:0]      max_q;
  logic [P-1:0]      max_d;

  // Error is carried alongside the result so it is ready at the output.
  always_comb begin
    full_c = (P+1)'($signed(bus.A)) * (P+1)'($signed(bus.B));
    diff_c = full_c - $signed({prod_c[P-1], prod_c});
    err_c  = diff_c[P] ? P'(-diff_c) : P'(diff_c);
  end

  always_comb begin
    ex_d  = ex_q;
    err_d = err_q;
    if (en) begin
      ex_d[0]  = bus.exact;
      err_d[0] = err_c;
      for (int s = 1; s < STAGES; s++) begin
        ex_d[s]  = ex_q[s-1];
        err_d[s] = err_q[s-1];
      end
    end
  end

  assign err_out = err_q[STAGES-1];
  assign fire    = vld_q[STAGES-1] && bus.out_ready &&
                   !ex_q[STAGES-1];

  always_comb begin
    cnt_d = cnt_q;
    sum_d = sum_q;
    max_d = max_q;
    sum_x = {1'b0, sum_q} + (SUM_W+1)'(err_out);
    if (stats_clr) begin
      cnt_d = '0;
      sum_d = '0;
      max_d = '0;
    end else if (fire) begin
      cnt_d = cnt_q + CNT_W'(1);
      sum_d = sum_x[SUM_W] ? '1 : sum_x[SUM_W-1:0];
      if (err_out > max_q)
        max_d = err_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      max_q <= '0;
      for (int s = 0; s < STAGES; s++)
        err_q[s] <= '0;
    end else begin
      ex_q  <= ex_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      max_q <= max_d;
    end
  end

  assign err_cnt = cnt_q;
  assign err_sum = sum_q;
  assign err_max = max_q;
`endif

endmodule
